button_debouncer: RTL and testbench
===================================

# button_debouncer

Multi-channel push-button/switch input conditioner for the board's user inputs. It is the input-side counterpart to the LED drive logic. Each raw, asynchronous, bouncing pin is synchronised into `clk`, held to a stability time, and presented as a clean level. One-cycle press/release pulses are generated for downstream control logic, e.g. starting a CNN inference run or stepping a debug display.

## Interface
Parameters:
- `N_BTN`, 4: number of independent input channels.
- `DEBOUNCE_CYCLES`, 1000000: number of consecutive stable samples required to accept a new level (10 ms at 100 MHz). Legal range is ≥ 1.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`: width of the per-channel stability counter.

Ports:
- `clk`, input, 1: sole clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `btn_in`, input, `N_BTN`: raw asynchronous pins, active-high (1 = pressed).
- `btn_level`, output, `N_BTN`: debounced level.
- `btn_press`, output, `N_BTN`: one-cycle pulse on an accepted 0→1 transition.
- `btn_release`, output, `N_BTN`: one-cycle pulse on an accepted 1→0 transition (see Configuration).

## Operation
Each channel is fully independent and has identical logic.
- **Synchroniser:** two flops, `s1 <= btn_in[i]` and `s2 <= s1`. Only `s2` feeds the state machine.
- **State machine (4 states):**
  - `STABLE0`: if `s2==1`, go to `PEND1` and set `cnt <= 0`.
  - `PEND1`: if `s2==0`, go to `STABLE0` and clear `cnt`. Else if `cnt==DEBOUNCE_CYCLES-1`, go to `STABLE1`. Else `cnt <= cnt+1`.
  - `STABLE1`: if `s2==0`, go to `PEND0` and set `cnt <= 0`.
  - `PEND0`: mirror of `PEND1`, with the opposite level, `STABLE1` as the abort target and `STABLE0` as the accept target.
- **Glitch rejection:** a single opposite sample in a `PEND` state aborts and restarts the count from zero. The stable level never toggles.
- **`btn_level`:** registered. It is 1 in `STABLE1` and `PEND0`, and 0 otherwise.
- **`btn_press`:** registered. It is 1 for exactly the one cycle after the `PEND1`→`STABLE1` edge.
- **`btn_release`:** registered. It is 1 for exactly the one cycle after the `PEND0`→`STABLE0` edge.
- **Counter:** it never exceeds `DEBOUNCE_CYCLES-1` and has no wrap-around path.
- **Reset:** on any edge with `rst=1`, all of the following are cleared: `s1`, `s2`, state (`STABLE0`), `cnt`, and all outputs (0). Reset overrides any in-progress count. A button held through reset is re-debounced afterwards and yields a fresh `btn_press`.

## Timing
- **Definition:** let E0 be the first rising edge at which the new value of `btn_in` is sampled into `s1`.
- **Synchroniser:** `s2` holds the value after E1. The state machine enters `PEND` at E2.
- **Latency:** `btn_level` changes, and the press/release pulse asserts, after edge E(`DEBOUNCE_CYCLES`+2). Total latency is `DEBOUNCE_CYCLES`+2 cycles, provided the input is held stable throughout.
- **Pulse width:** pulses last exactly 1 cycle. A pulse coincides with the first cycle of the new `btn_level`.
- **Pulse spacing:** consecutive pulses on one channel are at least `DEBOUNCE_CYCLES`+1 cycles apart.
- **Multiple channels:** simultaneous transitions on several channels give simultaneous pulses. There is no arbitration.
- **No input handshake:** the input must be held ≥ `DEBOUNCE_CYCLES`+1 sampled cycles after it reaches `s2` to be accepted.

## Configuration
- `BUTTON_RELEASE_PULSE_EN` defined: `btn_release` is generated as described above.
- `BUTTON_RELEASE_PULSE_EN` undefined:
  - `btn_release` is tied to constant 0.
  - The release-pulse register is removed.
  - `btn_level` and `btn_press` behaviour is unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `N_BTN=4`.
- **Reset:** hold `rst=1` for 3 cycles with `btn_in=4'hF` → all outputs are 0 during reset. `btn_level` reads `4'hF` after edge E6 counted from the first post-reset edge. `btn_press=4'hF` for 1 cycle.
- **Clean press:** raise `btn_in[0]` before edge E0 and hold → `btn_level[0]` rises after E6. `btn_press[0]` is high for exactly the cycle after E6, and 0 on all other channels.
- **Bounce:** toggle `btn_in[1]` 1,0,1,0,1 on single cycles, then hold it at 1 → no pulse during the bounce. One `btn_press[1]` arrives 6 cycles after the final rising sample.
- **Release:** from the pressed state, drop `btn_in[0]` →
  - with `BUTTON_RELEASE_PULSE_EN`: `btn_release[0]` pulses 1 cycle after E6 and `btn_level[0]` falls.
  - without it: `btn_release` stays `4'h0`.
- **Short glitch:** a 3-cycle high pulse on `btn_in[2]` → `btn_level[2]` stays 0 and no pulse is produced.
- **Reset mid-count:** assert `rst` for 1 cycle while channel 3 is in `PEND1` → no pulse is produced. With `btn_in[3]` still high, `btn_press[3]` fires 6 cycles after reset deasserts.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw pins in, debounced level and edge pulses out.
// The slave modport is the debouncer; the master modport is whoever drives the pins.
interface button_debouncer_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (output btn_in, input btn_level, input btn_press, input btn_release);
  modport slave  (input btn_in, output btn_level, output btn_press, output btn_release);
endinterface

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: 2-flop synchroniser, 4-state stability FSM and one-cycle press/release pulses.
// Optional feature macro: BUTTON_RELEASE_PULSE_EN (release pulses; otherwise btn_release is tied to 0).
module button_debouncer #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic               clk,
  input logic               rst,
  button_debouncer_if.slave bus
);

  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    PEND1   = 2'd1,
    STABLE1 = 2'd2,
    PEND0   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic   [N_BTN-1:0]            s1_q;
  logic   [N_BTN-1:0]            s2_q;
  state_t [N_BTN-1:0]            state_q;
  logic   [N_BTN-1:0][CNT_W-1:0] cnt_q;
  logic   [N_BTN-1:0]            level_q;
  logic   [N_BTN-1:0]            press_q;
`ifdef BUTTON_RELEASE_PULSE_EN
  logic   [N_BTN-1:0]            release_q;
`endif

  // Synchroniser, per-channel stability FSM and registered outputs; outputs follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      press_q <= '0;
`ifdef BUTTON_RELEASE_PULSE_EN
      release_q <= '0;
`endif
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= STABLE0;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q    <= bus.btn_in;
      s2_q    <= s1_q;
      press_q <= '0;
`ifdef BUTTON_RELEASE_PULSE_EN
      release_q <= '0;
`endif
      for (int i = 0; i < N_BTN; i++) begin
        case (state_q[i])
          STABLE0: begin
            if (s2_q[i]) begin
              state_q[i] <= PEND1;
              cnt_q[i]   <= '0;
            end
          end
          PEND1: begin
            if (!s2_q[i]) begin
              state_q[i] <= STABLE0;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_q[i] <= STABLE1;
              cnt_q[i]   <= '0;
              level_q[i] <= 1'b1;
              press_q[i] <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          STABLE1: begin
            if (!s2_q[i]) begin
              state_q[i] <= PEND0;
              cnt_q[i]   <= '0;
            end
          end
          PEND0: begin
            // A single high sample aborts back to the held level; the count restarts on the next drop.
            if (s2_q[i]) begin
              state_q[i] <= STABLE1;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_q[i] <= STABLE0;
              cnt_q[i]   <= '0;
              level_q[i] <= 1'b0;
`ifdef BUTTON_RELEASE_PULSE_EN
              release_q[i] <= 1'b1;
`endif
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_q[i] <= STABLE0;
            cnt_q[i]   <= '0;
            level_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_press = press_q;
`ifdef BUTTON_RELEASE_PULSE_EN
  assign bus.btn_release = release_q;
`else
  assign bus.btn_release = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (N_BTN=4, DEBOUNCE_CYCLES=4): expected outputs per cycle are
// queued when stimulus is scheduled and compared on the falling edge of the cycle they belong to.
module tb_button_debouncer;

  localparam int NB = 4;
  localparam int DC = 4;
  localparam int LAT = DC + 3;  // drive at negedge of cycle c -> E0 is edge c+1 -> change seen at cycle c+1+DC+2
  localparam int NEVER = 100000;

  typedef struct packed {
    int          cyc;
    logic [3:0]  lvl;
    logic [3:0]  prs;
    logic [3:0]  rel;
    logic [63:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  exp_t cur;

  button_debouncer_if #(.N_BTN(NB)) bus_if ();

  button_debouncer #(.N_BTN(NB), .DEBOUNCE_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Push one expectation per cycle in [from,to]; outputs switch to the new level at cycle chg.
  task automatic push_win(input int from, input int to, input int chg,
                          input logic [3:0] lvl_old, input logic [3:0] lvl_new,
                          input logic [3:0] prs, input logic [3:0] rel, input logic [63:0] tag);
    exp_t e;
    for (int t = from; t <= to; t++) begin
      e.cyc = t;
      e.lvl = (t >= chg) ? lvl_new : lvl_old;
      e.prs = (t == chg) ? prs : 4'h0;
`ifdef BUTTON_RELEASE_PULSE_EN
      e.rel = (t == chg) ? rel : 4'h0;
`else
      e.rel = 4'h0;
`endif
      e.tag = tag;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Scoreboard: pop every expectation due at this cycle and compare against the DUT outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      cur = sb_q.pop_front();
      n_cmp++;
      assert (cur.cyc == cyc) else begin
        n_bad++;
        $error("FAIL %0s late_expectation observed_cyc=%0d expected_cyc=%0d", cur.tag, cyc, cur.cyc);
      end
      n_cmp++;
      assert (bus_if.btn_level === cur.lvl) else begin
        n_bad++;
        $error("FAIL %0s level cyc=%0d observed=%h expected=%h", cur.tag, cyc, bus_if.btn_level, cur.lvl);
      end
      n_cmp++;
      assert (bus_if.btn_press === cur.prs) else begin
        n_bad++;
        $error("FAIL %0s press cyc=%0d observed=%h expected=%h", cur.tag, cyc, bus_if.btn_press, cur.prs);
      end
      n_cmp++;
      assert (bus_if.btn_release === cur.rel) else begin
        n_bad++;
        $error("FAIL %0s release cyc=%0d observed=%h expected=%h", cur.tag, cyc, bus_if.btn_release, cur.rel);
      end
    end
  end

  initial begin
    // Reset for 3 edges with all buttons held: outputs 0, then re-debounced press on all channels.
    rst = 1'b1;
    bus_if.btn_in = 4'hF;
    push_win(1, 11, 10, 4'h0, 4'hF, 4'hF, 4'h0, "reset");
    wait_cyc(3);
    rst = 1'b0;

    // Release every channel.
    push_win(13, 21, 12 + LAT, 4'hF, 4'h0, 4'h0, 4'hF, "rel_all");
    wait_cyc(12);
    bus_if.btn_in = 4'h0;

    // Clean press on channel 0.
    push_win(23, 31, 22 + LAT, 4'h0, 4'h1, 4'h1, 4'h0, "press0");
    wait_cyc(22);
    bus_if.btn_in = 4'h1;

    // Bounce 1,0,1,0,1 on channel 1, then hold; final rising drive at cycle 36.
    push_win(33, 45, 36 + LAT, 4'h1, 4'h3, 4'h2, 4'h0, "bounce1");
    wait_cyc(32); bus_if.btn_in = 4'h3;
    wait_cyc(33); bus_if.btn_in = 4'h1;
    wait_cyc(34); bus_if.btn_in = 4'h3;
    wait_cyc(35); bus_if.btn_in = 4'h1;
    wait_cyc(36); bus_if.btn_in = 4'h3;

    // Release channel 0 while channel 1 stays pressed.
    push_win(47, 55, 46 + LAT, 4'h3, 4'h2, 4'h0, 4'h1, "rel0");
    wait_cyc(46);
    bus_if.btn_in = 4'h2;

    // Three-cycle glitch on channel 2 must be rejected.
    push_win(57, 68, NEVER, 4'h2, 4'h2, 4'h0, 4'h0, "glitch2");
    wait_cyc(56); bus_if.btn_in = 4'h6;
    wait_cyc(59); bus_if.btn_in = 4'h2;

    // Reset while channel 3 is counting; channels 1 and 3 re-debounce afterwards.
    push_win(71, 74, NEVER, 4'h2, 4'h2, 4'h0, 4'h0, "pre_rst");
    push_win(75, 83, 82, 4'h0, 4'hA, 4'hA, 4'h0, "rst_mid");
    wait_cyc(70); bus_if.btn_in = 4'hA;
    wait_cyc(74); rst = 1'b1;
    wait_cyc(75); rst = 1'b0;

    wait_cyc(90);
    n_cmp++;
    assert (sb_q.size() == 0) else begin
      n_bad++;
      $error("FAIL drain pending observed=%0d expected=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
